// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles the request/grant handshake between the IF and DM requesters,
//   the memory completion pulse, and the mux/stall/timeout outputs of the
//   shared memory-port arbiter.
//   slave  : arbiter side (takes requests and done, drives grants/mux/stalls)
//   master : requester/pipeline side (drives requests and done)
interface mem_port_arbiter_if;
  logic req_if;
  logic req_dm;
  logic done;
  logic grant_if;
  logic grant_dm;
  logic sel;
  logic en;
  logic stall_if;
  logic stall_dm;
  logic timeout;

  modport slave (
    input  req_if, req_dm, done,
    output grant_if, grant_dm, sel, en, stall_if, stall_dm, timeout
  );

  modport master (
    output req_if, req_dm, done,
    input  grant_if, grant_dm, sel, en, stall_if, stall_dm, timeout
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Grants the single shared memory port to instruction fetch (IF) or data
//   memory (DM), holds the grant until done, and drives the steering mux
//   select/enable plus per-requester stalls.
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : handshake/mux/stall/timeout signals (slave modport)
//
//   state  | meaning
//   IDLE   | port unowned, mux disabled
//   GNT_IF | port owned by instruction fetch, sel=0
//   GNT_DM | port owned by data memory, sel=1
module mem_port_arbiter #(
  parameter int MAX_DM_RUN = 3,
  parameter int TIMEOUT    = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mem_port_arbiter_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, GNT_IF, GNT_DM} state_t;

  localparam logic [3:0] MAX_RUN   = 4'(MAX_DM_RUN);
  localparam logic [7:0] HOLD_LAST = 8'(TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [3:0] dm_run_q, dm_run_d;
  logic [7:0] hold_q, hold_d;
  logic [3:0] dm_run_sat;
  logic [3:0] run_eval;
  logic       issue;
  logic       to_pulse;

  function automatic state_t arbitrate(input logic r_if, input logic r_dm,
                                       input logic [3:0] run);
    if (r_if && r_dm) return (run == MAX_RUN) ? GNT_IF : GNT_DM;
    else if (r_dm)    return GNT_DM;
    else if (r_if)    return GNT_IF;
    else              return IDLE;
  endfunction

  assign dm_run_sat = (dm_run_q >= MAX_RUN) ? MAX_RUN : dm_run_q + 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      dm_run_q <= 4'd0;
      hold_q   <= 8'd0;
    end else begin
      state_q  <= state_d;
      dm_run_q <= dm_run_d;
      hold_q   <= hold_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    dm_run_d = dm_run_q;
    hold_d   = hold_q;
    run_eval = dm_run_q;
    issue    = 1'b0;
    to_pulse = 1'b0;

    case (state_q)
      IDLE: issue = 1'b1;
      GNT_IF: begin
        if (bus.done) begin
          issue = 1'b1;
        end else if (!bus.req_if) begin
          state_d = IDLE;
        end else if (hold_q == HOLD_LAST) begin
          to_pulse = 1'b1;
          state_d  = IDLE;
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      GNT_DM: begin
        if (bus.done) begin
          // The completing grant counts toward the run before deciding who
          // goes next, so IF is forced right after the MAX_DM_RUN-th completion.
          run_eval = bus.req_if ? dm_run_sat : 4'd0;
          dm_run_d = run_eval;
          issue    = 1'b1;
        end else if (!bus.req_dm) begin
          state_d = IDLE;
        end else if (hold_q == HOLD_LAST) begin
          to_pulse = 1'b1;
          state_d  = IDLE;
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (issue) begin
      state_d = arbitrate(bus.req_if, bus.req_dm, run_eval);
      hold_d  = 8'd0;
      if (state_d == GNT_IF) dm_run_d = 4'd0;
    end
  end

  assign bus.grant_if = (state_q == GNT_IF);
  assign bus.grant_dm = (state_q == GNT_DM);
  assign bus.sel      = (state_q == GNT_DM);
  assign bus.en       = (state_q != IDLE);
  assign bus.stall_if = bus.req_if & ~bus.grant_if;
  assign bus.stall_dm = bus.req_dm & ~bus.grant_dm;
  assign bus.timeout  = to_pulse;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.MAX_DM_RUN(3), .TIMEOUT(15)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One cycle: land just after the rising edge so registered outputs settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // {grant_if, grant_dm, sel, en}
  function automatic logic [7:0] outs();
    return {4'd0, bus.grant_if, bus.grant_dm, bus.sel, bus.en};
  endfunction

  initial begin
    checks   = 0;
    failures = 0;
    rst_n      = 1'b0;
    bus.req_if = 1'b1;
    bus.req_dm = 1'b0;
    bus.done   = 1'b0;

    // Reset with IF requesting
    #12;
    chk("rst_outs", outs(), 8'b0000);
    chk("rst_stall_if", {7'd0, bus.stall_if}, 8'd1);
    chk("rst_timeout", {7'd0, bus.timeout}, 8'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;

    // Single IF request granted one cycle after release
    step();
    chk("if_grant", outs(), 8'b1001);
    chk("if_stall", {7'd0, bus.stall_if}, 8'd0);
    bus.done = 1'b1; bus.req_if = 1'b0;
    step();
    bus.done = 1'b0;
    chk("if_done_idle", outs(), 8'b0000);

    // Simultaneous requests: three DM grants then IF, en never drops
    bus.req_if = 1'b1; bus.req_dm = 1'b1;
    step();
    chk("both_dm1", outs(), 8'b0111);
    chk("both_stall_if", {7'd0, bus.stall_if}, 8'd1);
    bus.done = 1'b1;
    step();
    chk("both_dm2", outs(), 8'b0111);
    step();
    chk("both_dm3", outs(), 8'b0111);
    step();
    chk("forced_if", outs(), 8'b1001);
    chk("forced_stall_dm", {7'd0, bus.stall_dm}, 8'd1);
    bus.req_if = 1'b0;
    step();
    chk("after_if_dm", outs(), 8'b0111);
    bus.req_dm = 1'b0;
    step();
    bus.done = 1'b0;
    chk("both_idle", outs(), 8'b0000);

    // Back-to-back handoff DM -> IF
    bus.req_dm = 1'b1;
    step();
    chk("ho_dm", outs(), 8'b0111);
    bus.req_if = 1'b1; bus.done = 1'b1; bus.req_dm = 1'b0;
    step();
    bus.done = 1'b0;
    chk("ho_if", outs(), 8'b1001);

    // Timeout: IF granted at G (now), no done
    for (int k = 1; k <= 13; k++) begin
      step();
      chk("to_pre", {6'd0, bus.en, bus.timeout}, 8'b10);
    end
    step();
    chk("to_pulse", {6'd0, bus.en, bus.timeout}, 8'b11);
    step();
    chk("to_idle", {6'd0, bus.en, bus.timeout}, 8'b00);
    step();
    chk("to_regrant", outs(), 8'b1001);

    // Withdrawal of IF then stray done in IDLE
    bus.req_if = 1'b0;
    step();
    chk("wd_if_idle", {6'd0, bus.en, bus.timeout}, 8'b00);
    bus.done = 1'b1;
    #1;
    chk("stray_to", {7'd0, bus.timeout}, 8'd0);
    step();
    bus.done = 1'b0;
    chk("stray_done", outs(), 8'b0000);

    // DM withdraws mid-grant
    bus.req_dm = 1'b1;
    step();
    step();
    chk("wd_dm_hold", outs(), 8'b0111);
    bus.req_dm = 1'b0;
    #1;
    chk("wd_dm_to", {7'd0, bus.timeout}, 8'd0);
    step();
    chk("wd_dm_idle", {3'd0, outs()[3:0], bus.timeout}, 8'b00000);

    // Async reset mid-grant after building a DM run of 2
    bus.req_if = 1'b1; bus.req_dm = 1'b1;
    step();
    bus.done = 1'b1;
    step();
    step();
    bus.done = 1'b0;
    chk("pre_rst_dm", outs(), 8'b0111);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_outs", outs(), 8'b0000);
    chk("arst_stall_dm", {7'd0, bus.stall_dm}, 8'd1);
    @(posedge clk);
    #3 rst_n = 1'b1;
    step();
    chk("post_rst_dm", outs(), 8'b0111);
    bus.done = 1'b1;
    step();
    chk("post_rst_run1", outs(), 8'b0111);
    step();
    chk("post_rst_run2", outs(), 8'b0111);
    step();
    chk("post_rst_if", outs(), 8'b1001);
    bus.done = 1'b0; bus.req_if = 1'b0; bus.req_dm = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
